// File: rtl/stp16_scan_controller.sv
// Row-scan sequencer for an STP16 LED driver: fetch a row word, shift it out, latch, then display.
// Optional macro STP16_SCAN_DIM_EN enables brightness-weighted on-time; otherwise on-time is full.
module stp16_scan_controller #(
  parameter int NUM_ROWS   = 4,
  parameter int CLK_DIV    = 2,
  parameter int ROW_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_enable,
  input  logic [3:0]                  i_brightness,
  output logic [$clog2(NUM_ROWS)-1:0] o_row_index,
  input  logic [15:0]                 i_row_data,
  output logic [NUM_ROWS-1:0]         o_row_sel,
  output logic                        o_frame_start,
  output logic                        stp16_clk,
  output logic                        stp16_sdi,
  output logic                        stp16_le,
  output logic                        stp16_noe
);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int CW = $clog2(ROW_CYCLES);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] LAST_CNT    = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] SEL_CNT     = CW'(CLK_DIV);
  localparam logic [CW-1:0] ON_CNT      = CW'(CLK_DIV + 1);
  localparam logic [CW-1:0] SHIFT_FIRST = CW'(CLK_DIV + 2);
  localparam logic [CW-1:0] SHIFT_END   = CW'(CLK_DIV + 2 + 32 * CLK_DIV);
  localparam logic [PW-1:0] PHASE_HIGH  = PW'(CLK_DIV);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(2 * CLK_DIV - 1);
  localparam logic [NUM_ROWS-1:0] ROW_ONE = {{(NUM_ROWS-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] ROW_LAST    = RW'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, SCAN = 2'd2} state_t;

  state_t              state_r, state_nxt_s;
  logic [CW-1:0]       cnt_r, cnt_nxt_s;
  logic                stop_r, stop_nxt_s;
  logic [3:0]          bright_s;
  logic [CW:0]         on_s, on_end_s;
  logic [15:0]         shreg_r, shreg_nxt_s;
  logic [PW-1:0]       phase_r, phase_nxt_s;
  logic [RW-1:0]       row_idx_r, row_idx_nxt_s;
  logic [NUM_ROWS-1:0] row_sel_r, row_sel_nxt_s;
  logic                fs_r, fs_nxt_s;
  logic                sclk_r, sclk_nxt_s;
  logic                sdi_r, sdi_nxt_s;
  logic                le_r, le_nxt_s;
  logic                noe_r, noe_nxt_s;

`ifdef STP16_SCAN_DIM_EN
  logic [3:0] bright_r;
  // Freeze the brightness seen at slot start for the rest of the slot
  always_ff @(posedge clk) begin
    if (reset) begin
      bright_r <= 4'd0;
    end else if (cnt_r == {CW{1'b0}}) begin
      bright_r <= i_brightness;
    end else begin
      bright_r <= bright_r;
    end
  end
  assign bright_s = bright_r;
`else
  logic unused_bright_s;
  assign unused_bright_s = ^i_brightness;
  assign bright_s        = 4'd15;
`endif

  assign on_s     = (CW+1)'({1'b0, bright_s} + 5'd1) << (CW - 4);
  assign on_end_s = {1'b0, ON_CNT} + on_s;

  // Sequencer state, slot counter and pending-stop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      stop_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      stop_r  <= stop_nxt_s;
    end
  end

  // Next state: a dropped enable only takes effect at the slot wrap
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stop_nxt_s  = stop_r;
    case (state_r)
      IDLE: begin
        cnt_nxt_s  = {CW{1'b0}};
        stop_nxt_s = 1'b0;
        if (i_enable) state_nxt_s = PRIME;
        else          state_nxt_s = IDLE;
      end
      PRIME, SCAN: begin
        if (cnt_r == LAST_CNT) begin
          cnt_nxt_s  = {CW{1'b0}};
          stop_nxt_s = 1'b0;
          if (stop_r || !i_enable) state_nxt_s = IDLE;
          else                     state_nxt_s = SCAN;
        end else begin
          cnt_nxt_s  = cnt_r + CW'(1'b1);
          stop_nxt_s = stop_r | ~i_enable;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
        stop_nxt_s  = 1'b0;
      end
    endcase
  end

  // Output values for the coming cycle, computed from the next slot position
  always_comb begin
    le_nxt_s      = 1'b0;
    noe_nxt_s     = 1'b1;
    sclk_nxt_s    = 1'b0;
    sdi_nxt_s     = 1'b0;
    fs_nxt_s      = 1'b0;
    row_sel_nxt_s = row_sel_r;
    row_idx_nxt_s = row_idx_r;
    shreg_nxt_s   = shreg_r;
    phase_nxt_s   = phase_r;
    if (state_nxt_s == IDLE) begin
      row_sel_nxt_s = {NUM_ROWS{1'b0}};
      row_idx_nxt_s = {RW{1'b0}};
      phase_nxt_s   = {PW{1'b0}};
    end else begin
      if (state_nxt_s == SCAN) begin
        le_nxt_s = (cnt_nxt_s < SEL_CNT);
        if (cnt_nxt_s >= ON_CNT && {1'b0, cnt_nxt_s} < on_end_s && cnt_nxt_s != LAST_CNT) begin
          noe_nxt_s = 1'b0;
        end else begin
          noe_nxt_s = 1'b1;
        end
        if (cnt_nxt_s == SEL_CNT) begin
          row_sel_nxt_s = ROW_ONE << row_idx_r;
          row_idx_nxt_s = (row_idx_r == ROW_LAST) ? {RW{1'b0}} : row_idx_r + RW'(1'b1);
          fs_nxt_s      = (row_idx_r == {RW{1'b0}});
        end else begin
          row_sel_nxt_s = row_sel_r;
          row_idx_nxt_s = row_idx_r;
        end
      end else begin
        // The priming slot always fetches row 0 with the matrix dark
        row_sel_nxt_s = {NUM_ROWS{1'b0}};
        row_idx_nxt_s = {RW{1'b0}};
      end
      if (cnt_nxt_s == SHIFT_FIRST) begin
        sdi_nxt_s   = i_row_data[15];
        shreg_nxt_s = {i_row_data[14:0], 1'b0};
        phase_nxt_s = {PW{1'b0}};
        sclk_nxt_s  = 1'b0;
      end else if (cnt_nxt_s > SHIFT_FIRST && cnt_nxt_s < SHIFT_END) begin
        if (phase_r == PHASE_LAST) begin
          phase_nxt_s = {PW{1'b0}};
          sdi_nxt_s   = shreg_r[15];
          shreg_nxt_s = {shreg_r[14:0], 1'b0};
        end else begin
          phase_nxt_s = phase_r + PW'(1'b1);
          sdi_nxt_s   = sdi_r;
        end
        sclk_nxt_s = (phase_nxt_s >= PHASE_HIGH);
      end else begin
        sdi_nxt_s   = 1'b0;
        sclk_nxt_s  = 1'b0;
        phase_nxt_s = {PW{1'b0}};
      end
    end
  end

  // Registered outputs and shift datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      le_r      <= 1'b0;
      noe_r     <= 1'b1;
      sclk_r    <= 1'b0;
      sdi_r     <= 1'b0;
      fs_r      <= 1'b0;
      row_sel_r <= {NUM_ROWS{1'b0}};
      row_idx_r <= {RW{1'b0}};
      shreg_r   <= 16'h0000;
      phase_r   <= {PW{1'b0}};
    end else begin
      le_r      <= le_nxt_s;
      noe_r     <= noe_nxt_s;
      sclk_r    <= sclk_nxt_s;
      sdi_r     <= sdi_nxt_s;
      fs_r      <= fs_nxt_s;
      row_sel_r <= row_sel_nxt_s;
      row_idx_r <= row_idx_nxt_s;
      shreg_r   <= shreg_nxt_s;
      phase_r   <= phase_nxt_s;
    end
  end

  assign o_row_index   = row_idx_r;
  assign o_row_sel     = row_sel_r;
  assign o_frame_start = fs_r;
  assign stp16_clk     = sclk_r;
  assign stp16_sdi     = sdi_r;
  assign stp16_le      = le_r;
  assign stp16_noe     = noe_r;

endmodule

// File: tb/tb_stp16_scan_controller.sv
// Self-checking bench for stp16_scan_controller at default parameters (4 rows, CLK_DIV 2, 256-cycle slots).
module tb_stp16_scan_controller;
`ifdef STP16_SCAN_DIM_EN
  localparam bit DIM = 1'b1;
`else
  localparam bit DIM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, i_enable;
  logic [3:0]  i_brightness;
  logic [1:0]  o_row_index;
  logic [15:0] i_row_data;
  logic [3:0]  o_row_sel;
  logic        o_frame_start, stp16_clk, stp16_sdi, stp16_le, stp16_noe;
  logic [15:0] mem [4];

  typedef struct packed {
    logic [255:0] le_v, clk_v, noe_v, fs_v;
    logic [15:0]  word;
    logic [7:0]   rises;
    logic         sdi_bad;
    logic [3:0]   rs2, rs255;
    logic [1:0]   idx;
  } slot_t;

  typedef struct {
    logic [3:0]  bright;
    int          noe_hi;
    logic        fs;
    logic [15:0] word;
    logic [3:0]  rs;
    logic [1:0]  idx;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  slot_t sb_q[$];
  slot_t e, o;
  vec_t  tbl[5];
  logic [3:0] nb;

  stp16_scan_controller dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_brightness(i_brightness),
    .o_row_index(o_row_index), .i_row_data(i_row_data), .o_row_sel(o_row_sel),
    .o_frame_start(o_frame_start), .stp16_clk(stp16_clk), .stp16_sdi(stp16_sdi),
    .stp16_le(stp16_le), .stp16_noe(stp16_noe)
  );

  always #5 clk = ~clk;

  // Row buffer: registered read, data valid one cycle after the address changes
  always @(posedge clk) i_row_data <= mem[o_row_index];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic slot_t mk_exp(input bit scan, input int hi, input bit fs,
                                   input logic [15:0] word, input logic [3:0] rs, input logic [1:0] idx);
    slot_t x;
    x = '0;
    for (int c = 0; c < 256; c++) begin
      x.le_v[c]  = scan && (c < 2);
      x.clk_v[c] = (c >= 4) && (c < 68) && (((c - 4) % 4) >= 2);
      x.noe_v[c] = !(scan && (c >= 3) && (c <= hi));
      x.fs_v[c]  = fs && (c == 2);
    end
    x.word = word; x.rises = 8'd16; x.sdi_bad = 1'b0;
    x.rs2 = rs; x.rs255 = rs; x.idx = idx;
    return x;
  endfunction

  // Run one full slot starting at slot_cnt 0, recording per-cycle behaviour
  task automatic run_slot(input logic [3:0] cur_b, input logic [3:0] next_b, input int drop_at, output slot_t r);
    logic prev_clk;
    r = '0;
    prev_clk = 1'b0;
    for (int c = 0; c < 256; c++) begin
      r.le_v[c]  = stp16_le;
      r.clk_v[c] = stp16_clk;
      r.noe_v[c] = stp16_noe;
      r.fs_v[c]  = o_frame_start;
      if (stp16_clk && !prev_clk) begin
        r.word  = {r.word[14:0], stp16_sdi};
        r.rises = r.rises + 8'd1;
      end
      if ((c < 4 || c >= 68) && stp16_sdi !== 1'b0) r.sdi_bad = 1'b1;
      prev_clk = stp16_clk;
      if (c == 2) r.rs2 = o_row_sel;
      if (c == 255) begin
        r.rs255 = o_row_sel;
        r.idx   = o_row_index;
      end
      if (c == 50) i_brightness = ~cur_b;
      if (c == drop_at) i_enable = 1'b0;
      if (c == 255) i_brightness = next_b;
      step();
    end
  endtask

  task automatic check_slot(input string tag, input slot_t x, input slot_t r);
    cmp({tag, "_le"},     r.le_v,  x.le_v);
    cmp({tag, "_sclk"},   r.clk_v, x.clk_v);
    cmp({tag, "_noe"},    r.noe_v, x.noe_v);
    cmp({tag, "_fs"},     r.fs_v,  x.fs_v);
    cmp({tag, "_word"},   256'(r.word),    256'(x.word));
    cmp({tag, "_rises"},  256'(r.rises),   256'(x.rises));
    cmp({tag, "_sdi0"},   256'(r.sdi_bad), 256'(x.sdi_bad));
    cmp({tag, "_rs2"},    256'(r.rs2),     256'(x.rs2));
    cmp({tag, "_rs255"},  256'(r.rs255),   256'(x.rs255));
    cmp({tag, "_idx"},    256'(r.idx),     256'(x.idx));
  endtask

  initial begin
    tbl[0] = '{4'd0,  DIM ? 18  : 254, 1'b1, 16'h00FF, 4'b0001, 2'd1};
    tbl[1] = '{4'd15, 254,             1'b0, 16'hFFFF, 4'b0010, 2'd2};
    tbl[2] = '{4'd7,  DIM ? 130 : 254, 1'b0, 16'h0000, 4'b0100, 2'd3};
    tbl[3] = '{4'd3,  DIM ? 66  : 254, 1'b0, 16'h8001, 4'b1000, 2'd0};
    tbl[4] = '{4'd1,  DIM ? 34  : 254, 1'b1, 16'h00FF, 4'b0001, 2'd1};
    mem[0] = 16'h8001; mem[1] = 16'h00FF; mem[2] = 16'hFFFF; mem[3] = 16'h0000;

    reset = 1'b1; i_enable = 1'b0; i_brightness = 4'd0;
    repeat (3) step();
    cmp("rst_noe",     256'(stp16_noe), 256'(1'b1));
    cmp("rst_serial",  256'({stp16_clk, stp16_sdi, stp16_le}), 256'(3'b000));
    cmp("rst_row_sel", 256'(o_row_sel), 256'(4'b0000));
    cmp("rst_idx_fs",  256'({o_row_index, o_frame_start}), 256'(3'b000));

    reset = 1'b0; i_enable = 1'b1;
    step();
    sb_q.push_back(mk_exp(1'b0, 0, 1'b0, 16'h8001, 4'b0000, 2'd0));
    run_slot(4'd0, tbl[0].bright, -1, o);
    e = sb_q.pop_front();
    check_slot("prime", e, o);

    for (int k = 0; k < 5; k++) begin
      if (k < 4) nb = tbl[k+1].bright;
      else       nb = 4'd15;
      sb_q.push_back(mk_exp(1'b1, tbl[k].noe_hi, tbl[k].fs, tbl[k].word, tbl[k].rs, tbl[k].idx));
      run_slot(tbl[k].bright, nb, -1, o);
      e = sb_q.pop_front();
      check_slot($sformatf("scan%0d", k), e, o);
    end

    // Enable dropped mid-slot: the slot completes, then the block idles
    run_slot(4'd15, 4'd15, 100, o);
    cmp("drop_le_start", 256'(o.le_v[1:0]), 256'(2'b11));
    cmp("drop_noe_late", 256'(o.noe_v[200]), 256'(1'b0));
    cmp("drop_rs_end",   256'(o.rs255), 256'(4'b0010));
    cmp("idle_noe_rs",   256'({stp16_noe, o_row_sel}), 256'(5'b10000));
    cmp("idle_le_idx",   256'({stp16_le, o_row_index}), 256'(3'b000));
    step();
    cmp("idle_le_hold",  256'(stp16_le), 256'(1'b0));
    repeat (20) step();
    cmp("idle_clk_noe",  256'({stp16_clk, stp16_noe}), 256'(2'b01));

    // Re-enable restarts at PRIME with row 0
    i_enable = 1'b1;
    step();
    run_slot(4'd15, 4'd15, -1, o);
    cmp("re_prime_word", 256'(o.word), 256'(16'h8001));
    cmp("re_prime_rs",   256'(o.rs255), 256'(4'b0000));
    cmp("re_prime_noe",  o.noe_v, {256{1'b1}});
    for (int c = 0; c < 40; c++) begin
      if (c == 0) cmp("re_le", 256'(stp16_le), 256'(1'b1));
      if (c == 2) cmp("re_row0_fs", 256'({o_row_sel, o_frame_start}), 256'(5'b00011));
      step();
    end
    cmp("pre_rst_noe", 256'(stp16_noe), 256'(1'b0));
    reset = 1'b1;
    step();
    cmp("mid_rst_noe",    256'(stp16_noe), 256'(1'b1));
    cmp("mid_rst_serial", 256'({stp16_clk, stp16_sdi, stp16_le}), 256'(3'b000));
    cmp("mid_rst_rows",   256'({o_row_sel, o_row_index, o_frame_start}), 256'(7'd0));
    reset = 1'b0; i_enable = 1'b0;
    repeat (3) step();
    cmp("post_rst_idle",  256'({stp16_le, stp16_noe, o_row_sel}), 256'(6'b010000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
